// File: rtl/replication_pkg.sv
// Shared types, constants and the encoder equation for the five-input replication
// similarity code.
package replication_pkg;

    localparam int N_IN = 5;
    localparam int W    = 25;

    typedef logic [W-1:0] sim_word_t;

    localparam int DIAG_IDX[N_IN] = '{24, 18, 12, 6, 0};

    // Bit positions inside the {cons_err, sym_err, diag_err} error vector.
    localparam int ERR_DIAG = 0;
    localparam int ERR_SYM  = 1;
    localparam int ERR_CONS = 2;
    localparam int ERR_W    = 3;

    // x[4] is source bit a, x[0] is source bit e.
    function automatic sim_word_t sim_encode(input logic [N_IN-1:0] x);
        sim_word_t w;
        w = '0;
        for (int i = 0; i < N_IN; i++) begin
            for (int j = 0; j < N_IN; j++) begin
                w[W-1-N_IN*i-j] = ~(x[N_IN-1-i] ^ x[N_IN-1-j]);
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/replication_checker.sv
// Structural checks on a similarity word: every diagonal bit must be 1 and the
// 5x5 matrix must be symmetric.
module replication_checker
    import replication_pkg::*;
(
    input  sim_word_t word_i,
    output logic      diag_err_o,
    output logic      sym_err_o
);

    always_comb begin
        diag_err_o = 1'b0;
        sym_err_o  = 1'b0;
        for (int k = 0; k < N_IN; k++) begin
            if (!word_i[DIAG_IDX[k]]) begin
                diag_err_o = 1'b1;
            end
        end
        for (int i = 0; i < N_IN; i++) begin
            for (int j = i + 1; j < N_IN; j++) begin
                if (word_i[W-1-N_IN*i-j] != word_i[W-1-N_IN*j-i]) begin
                    sym_err_o = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/replication_decoder.sv
// Two-stage valid/ready decoder for replication similarity words: S1 decodes row 0 and
// runs the structural checks, S2 re-encodes and compares, and holds the outputs.
module replication_decoder
    import replication_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_word,
    input  logic             in_anchor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_IN-1:0]  out_data,
    output logic [ERR_W-1:0] out_err,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] err_cnt,
    input  logic             clr_cnt
);

    logic             s1_valid_q;
    sim_word_t        s1_word_q;
    logic [N_IN-1:0]  s1_data_q;
    logic             s1_diag_q;
    logic             s1_sym_q;

    logic             s2_valid_q;
    logic [N_IN-1:0]  s2_data_q;
    logic [ERR_W-1:0] s2_err_q;

    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic             s1_adv;
    logic             s2_adv;
    logic             out_hs;
    logic [N_IN-1:0]  dec_data;
    logic             diag_err;
    logic             sym_err;
    logic             cons_err;
    logic [ERR_W-1:0] s1_err;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;
    assign out_hs   = s2_valid_q && out_ready;

    // Row 0 holds ~(a ^ xj); xoring with the anchor recovers xj directly.
    assign dec_data = {N_IN{in_anchor}} ^ ~in_word[W-1 -: N_IN];

    replication_checker u_checker (
        .word_i     (in_word),
        .diag_err_o (diag_err),
        .sym_err_o  (sym_err)
    );

    assign cons_err = (sim_encode(s1_data_q) != s1_word_q);

    always_comb begin
        s1_err           = '0;
        s1_err[ERR_CONS] = cons_err;
        s1_err[ERR_SYM]  = s1_sym_q;
        s1_err[ERR_DIAG] = s1_diag_q;
    end

    always_comb begin
        word_cnt_d = word_cnt_q;
        err_cnt_d  = err_cnt_q;
        if (clr_cnt) begin
            word_cnt_d = '0;
            err_cnt_d  = '0;
        end else if (out_hs) begin
            word_cnt_d = word_cnt_q + CNT_W'(1);
            if (|s2_err_q && (err_cnt_q != '1)) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_word_q  <= '0;
            s1_data_q  <= '0;
            s1_diag_q  <= 1'b0;
            s1_sym_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_err_q   <= '0;
            word_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_word_q <= in_word;
                    s1_data_q <= dec_data;
                    s1_diag_q <= diag_err;
                    s1_sym_q  <= sym_err;
                end
            end
            if (s2_adv) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_data_q <= s1_data_q;
                    s2_err_q  <= s1_err;
                end
            end
            word_cnt_q <= word_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign out_err   = s2_err_q;
    assign word_cnt  = word_cnt_q;
    assign err_cnt   = err_cnt_q;

endmodule
